// File: rtl/fulladder.sv
// Ripple-carry full adder (WIDTH cells, carry-in c enters bit 0) with combinational and registered outputs.
// Optional build macro FULLADDER_OVF_EN adds signed-overflow outputs ovf/ovf_q.
module fulladder #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
`ifdef FULLADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // chain[i] is the carry into cell i; chain[WIDTH] is the carry out of the MSB cell.
  logic [WIDTH:0] chain;

  always_comb begin
    chain    = '0;
    sum      = '0;
    chain[0] = c;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a[i] ^ b[i] ^ chain[i];
      chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
  end

  assign carry = chain[WIDTH];

`ifdef FULLADDER_OVF_EN
  // Signed overflow: the MSB cell's carry-in and carry-out disagree.
  assign ovf = chain[WIDTH-1] ^ chain[WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef FULLADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (en) begin
      sum_q   <= sum;
      carry_q <= carry;
`ifdef FULLADDER_OVF_EN
      ovf_q   <= ovf;
`endif
    end
  end

endmodule

// File: tb/tb_fulladder.sv
// Directed self-checking bench for fulladder: a 1-bit cell and an 8-bit ripple instance.
// Overflow checks are compiled in when FULLADDER_OVF_EN is defined.
module tb_fulladder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a1, b1, c1;
  logic       sum1, carry1, sum1_q, carry1_q;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] sum8, sum8_q;
  logic       carry8, carry8_q;
`ifdef FULLADDER_OVF_EN
  logic       ovf1, ovf1_q, ovf8, ovf8_q;
`endif

  int compared = 0;
  int mismatched = 0;

  fulladder #(.WIDTH(1)) u1 (
    .sum(sum1), .carry(carry1), .a(a1), .b(b1), .c(c1),
    .clk(clk), .rst(rst), .en(en), .sum_q(sum1_q), .carry_q(carry1_q)
`ifdef FULLADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf1_q)
`endif
  );

  fulladder #(.WIDTH(8)) u8 (
    .sum(sum8), .carry(carry8), .a(a8), .b(b8), .c(c8),
    .clk(clk), .rst(rst), .en(en), .sum_q(sum8_q), .carry_q(carry8_q)
`ifdef FULLADDER_OVF_EN
    , .ovf(ovf8), .ovf_q(ovf8_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ia, input logic ib, input logic ic);
    a1 = ia;
    b1 = ib;
    c1 = ic;
  endtask

  task automatic applyWide(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    a8 = ia;
    b8 = ib;
    c8 = ic;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected {carry,sum} and ovf for the eight 1-bit input combinations, indexed by {a,b,c}.
  logic [1:0] exp1 [8];
  logic       expOvf1 [8];

  initial begin
    exp1    = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    expOvf1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    en  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyWide(8'h00, 8'h00, 1'b0);

    // Exhaustive 1-bit truth table, 10 time units apart.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      vec = 3'(v);
      applyStimulus(vec[2], vec[1], vec[0]);
      #1;
      checkOutput($sformatf("comb1_%0d", v), {62'd0, carry1, sum1}, {62'd0, exp1[v]});
`ifdef FULLADDER_OVF_EN
      checkOutput($sformatf("ovf1_%0d", v), {63'd0, ovf1}, {63'd0, expOvf1[v]});
`endif
      #9;
    end

    // Reset for one edge clears the registers.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_sum_q", {63'd0, sum1_q}, 64'd0);
    checkOutput("rst_carry_q", {63'd0, carry1_q}, 64'd0);
    checkOutput("rst_sum8_q", {56'd0, sum8_q}, 64'd0);
    checkOutput("rst_carry8_q", {63'd0, carry8_q}, 64'd0);
`ifdef FULLADDER_OVF_EN
    checkOutput("rst_ovf1_q", {63'd0, ovf1_q}, 64'd0);
    checkOutput("rst_ovf8_q", {63'd0, ovf8_q}, 64'd0);
`endif

    // Load 1+1+0 with one cycle of latency.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("pre_load_carry_q", {63'd0, carry1_q}, 64'd0);
    @(posedge clk); #1;
    checkOutput("load_sum_q", {63'd0, sum1_q}, 64'd0);
    checkOutput("load_carry_q", {63'd0, carry1_q}, 64'd1);

    // Hold with en low while inputs change.
    @(negedge clk);
    en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_sum_q_%0d", k), {63'd0, sum1_q}, 64'd0);
      checkOutput($sformatf("hold_carry_q_%0d", k), {63'd0, carry1_q}, 64'd1);
    end
    checkOutput("hold_comb_sum", {63'd0, sum1}, 64'd1);

    // Reset wins over enable; combinational path unaffected.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("prio_sum_q", {63'd0, sum1_q}, 64'd0);
    checkOutput("prio_carry_q", {63'd0, carry1_q}, 64'd0);
    checkOutput("prio_comb", {62'd0, carry1, sum1}, 64'd3);

    // Releasing reset with en high loads 1+1+1.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("load111_q", {62'd0, carry1_q, sum1_q}, 64'd3);

    // 8-bit ripple vectors.
    @(negedge clk);
    en = 1'b0;
    applyWide(8'hFF, 8'h00, 1'b1); #1;
    checkOutput("w8_ff_00_1", {55'd0, carry8, sum8}, {55'd0, 1'b1, 8'h00});
    applyWide(8'h7F, 8'h01, 1'b0); #1;
    checkOutput("w8_7f_01_0", {55'd0, carry8, sum8}, {55'd0, 1'b0, 8'h80});
`ifdef FULLADDER_OVF_EN
    checkOutput("w8_ovf_7f_01", {63'd0, ovf8}, 64'd1);
`endif
    applyWide(8'hFF, 8'hFF, 1'b1); #1;
    checkOutput("w8_allones", {55'd0, carry8, sum8}, {55'd0, 1'b1, 8'hFF});
`ifdef FULLADDER_OVF_EN
    checkOutput("w8_ovf_allones", {63'd0, ovf8}, 64'd0);
`endif
    applyWide(8'h00, 8'h00, 1'b0); #1;
    checkOutput("w8_zeros", {55'd0, carry8, sum8}, 64'd0);
    applyWide(8'hA5, 8'h5A, 1'b0); #1;
    checkOutput("w8_a5_5a", {55'd0, carry8, sum8}, {55'd0, 1'b0, 8'hFF});
    applyWide(8'h80, 8'h80, 1'b0); #1;
    checkOutput("w8_80_80", {55'd0, carry8, sum8}, {55'd0, 1'b1, 8'h00});
`ifdef FULLADDER_OVF_EN
    checkOutput("w8_ovf_80_80", {63'd0, ovf8}, 64'd1);
`endif
    applyWide(8'hFF, 8'h01, 1'b0); #1;
    checkOutput("w8_ff_01", {55'd0, carry8, sum8}, {55'd0, 1'b1, 8'h00});
`ifdef FULLADDER_OVF_EN
    checkOutput("w8_ovf_ff_01", {63'd0, ovf8}, 64'd0);
`endif
    applyWide(8'h3C, 8'h0F, 1'b1); #1;
    checkOutput("w8_3c_0f_1", {55'd0, carry8, sum8}, {55'd0, 1'b0, 8'h4C});

    // Registered 8-bit path.
    @(negedge clk);
    en = 1'b1;
    applyWide(8'h7F, 8'h01, 1'b0);
    @(posedge clk); #1;
    checkOutput("w8_sum_q", {55'd0, carry8_q, sum8_q}, {55'd0, 1'b0, 8'h80});
`ifdef FULLADDER_OVF_EN
    checkOutput("w8_ovf_q", {63'd0, ovf8_q}, 64'd1);
`endif
    @(negedge clk);
    applyWide(8'hC3, 8'h4D, 1'b1);
    @(posedge clk); #1;
    checkOutput("w8_sum_q2", {55'd0, carry8_q, sum8_q}, {55'd0, 1'b1, 8'h11});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
